// File: rtl/mem_sdp_be.sv
// Simple dual-port SRAM with per-byte write enables, registered read path,
// selectable read-during-write result and an optional post-reset zero sweep.
module mem_sdp_be #(
  parameter int WD         = 128,
  parameter int DEPTH      = 64,
  parameter int WA         = $clog2(DEPTH),
  parameter int NB         = WD / 8,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  output logic          init_done_o,
  input  logic          wr_en_i,
  input  logic [WA-1:0] wr_addr_i,
  input  logic [WD-1:0] wr_din_i,
  input  logic [NB-1:0] wr_be_i,
  input  logic          rd_en_i,
  input  logic [WA-1:0] rd_addr_i,
  output logic [WD-1:0] rd_dout_o,
  output logic          rd_valid_o
);

  // One extra bit so the range compare is meaningful when DEPTH is a power of 2.
  localparam logic [WA:0]   DEPTH_X = (WA+1)'(DEPTH);
  localparam logic [WA-1:0] LAST    = WA'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;
  localparam state_e RST_STATE = (CLR_ON_RST != 0) ? S_CLEAR : S_RUN;

  state_e        state_q, state_d;
  logic [WA-1:0] cnt_q, cnt_d;
  logic          run;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign run         = (state_q == S_RUN);
  assign init_done_o = run;

  // Write port: the clear sweep owns it until the FSM reaches RUN.
  logic          wr_in_rng;
  logic          mem_we;
  logic [WA-1:0] mem_addr;
  logic [WD-1:0] mem_din;
  logic [NB-1:0] mem_be;

  assign wr_in_rng = ({1'b0, wr_addr_i} < DEPTH_X);

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_addr_i;
    mem_din  = wr_din_i;
    mem_be   = wr_be_i;
    if (!rstn_i) begin
      mem_we = 1'b0;
    end else if (!run) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
      mem_din  = '0;
      mem_be   = '1;
    end else begin
      mem_we = wr_en_i && wr_in_rng && (|wr_be_i);
    end
  end

  logic [WD-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem_q[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end
    end
  end

  // Read port: out-of-range reads complete normally with zero data.
  logic          rd_in_rng;
  logic          rd_fire;
  logic          rdw_hit;
  logic [WD-1:0] rd_old;
  logic [WD-1:0] rd_word;

  assign rd_in_rng = ({1'b0, rd_addr_i} < DEPTH_X);
  assign rd_fire   = run && rd_en_i;
  assign rd_old    = rd_in_rng ? mem_q[rd_addr_i] : '0;
  assign rdw_hit   = (RDW_MODE != 0) && run && mem_we && rd_in_rng &&
                     (wr_addr_i == rd_addr_i);

  always_comb begin
    rd_word = rd_old;
    for (int b = 0; b < NB; b++) begin
      if (rdw_hit && wr_be_i[b]) rd_word[8*b +: 8] = wr_din_i[8*b +: 8];
    end
  end

  logic          out_vld;
  logic [WD-1:0] out_dat;

  if (OUT_REG != 0) begin : g_oreg
    logic          v1_q;
    logic [WD-1:0] d1_q;
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        v1_q <= 1'b0;
        d1_q <= '0;
      end else begin
        v1_q <= rd_fire;
        if (rd_fire) d1_q <= rd_word;
      end
    end
    assign out_vld = v1_q;
    assign out_dat = d1_q;
  end else begin : g_noreg
    assign out_vld = rd_fire;
    assign out_dat = rd_word;
  end

  logic          rd_valid_q;
  logic [WD-1:0] rd_dout_q;

  // Data holds between reads; only the valid bit returns to zero.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_valid_q <= 1'b0;
      rd_dout_q  <= '0;
    end else begin
      rd_valid_q <= out_vld;
      if (out_vld) rd_dout_q <= out_dat;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_dout_o  = rd_dout_q;

endmodule

// File: tb/tb_mem_sdp_be.sv
// Directed bench: dut0 (64 words, latency 1, old-data RDW), dut1 (48 words,
// latency 2, merged RDW) and dut2 (no clear sweep) share one stimulus stream.
module tb_mem_sdp_be;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en, rd_en;
  logic [5:0]  wr_addr, rd_addr;
  logic [31:0] wr_din;
  logic [3:0]  wr_be;

  logic        done0, done1, done2;
  logic        v0, v1, v2;
  logic [31:0] d0, d1;
  logic [15:0] d2;

  always #5 clk = ~clk;

  mem_sdp_be #(.WD(32), .DEPTH(64), .OUT_REG(0), .RDW_MODE(0), .CLR_ON_RST(1)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .init_done_o(done0),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_din_i(wr_din), .wr_be_i(wr_be),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_dout_o(d0), .rd_valid_o(v0));

  mem_sdp_be #(.WD(32), .DEPTH(48), .OUT_REG(1), .RDW_MODE(1), .CLR_ON_RST(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .init_done_o(done1),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_din_i(wr_din), .wr_be_i(wr_be),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_dout_o(d1), .rd_valid_o(v1));

  mem_sdp_be #(.WD(16), .DEPTH(5), .OUT_REG(0), .RDW_MODE(0), .CLR_ON_RST(0)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .init_done_o(done2),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr[2:0]), .wr_din_i(wr_din[15:0]), .wr_be_i(wr_be[1:0]),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr[2:0]), .rd_dout_o(d2), .rd_valid_o(v2));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef enum int {OP_W, OP_R, OP_RW} op_e;
  typedef struct {
    string       name;
    op_e         op;
    logic [5:0]  waddr;
    logic [31:0] din;
    logic [3:0]  be;
    logic [5:0]  raddr;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  function automatic vec_t mk(string name, op_e op, logic [5:0] wa, logic [31:0] din,
                              logic [3:0] be, logic [5:0] ra, logic [31:0] e0, logic [31:0] e1);
    vec_t v;
    v.name = name; v.op = op; v.waddr = wa; v.din = din; v.be = be;
    v.raddr = ra; v.exp0 = e0; v.exp1 = e1;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    if (v.op != OP_R) begin
      wr_en = 1'b1; wr_addr = v.waddr; wr_din = v.din; wr_be = v.be;
    end
    if (v.op != OP_W) begin
      rd_en = 1'b1; rd_addr = v.raddr;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (v.op != OP_W) begin
      chk({v.name, " v0"}, 32'(v0), 32'd1);
      chk({v.name, " d0"}, d0, v.exp0);
      chk({v.name, " v1 early"}, 32'(v1), 32'd0);
      @(posedge clk); #1;
      chk({v.name, " v1"}, 32'(v1), 32'd1);
      chk({v.name, " d1"}, d1, v.exp1);
      chk({v.name, " v0 drop"}, 32'(v0), 32'd0);
      chk({v.name, " d0 hold"}, d0, v.exp0);
    end
  endtask

  // Releases reset at a negedge and counts edges until each init_done rises,
  // while hammering writes to addr 40 and reads of addr 0 that must be ignored.
  task automatic sweep(input string name);
    int a0 = 0, a1 = 0, bad = 0;
    @(negedge clk);
    rstn = 1'b1;
    wr_en = 1'b1; wr_addr = 6'd40; wr_din = 32'hFFFF_FFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 6'd0;
    for (int k = 1; k <= 100 && (a0 == 0 || a1 == 0); k++) begin
      @(posedge clk); #1;
      if (done0 && a0 == 0) a0 = k;
      if (done1 && a1 == 0) a1 = k;
      if (v0 || v1) bad++;
      if (k == 40) begin wr_en = 1'b0; rd_en = 1'b0; end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk({name, " done0 cycle"}, 32'(a0), 32'd64);
    chk({name, " done1 cycle"}, 32'(a1), 32'd48);
    chk({name, " no valid in clear"}, 32'(bad), 32'd0);
  endtask

  vec_t tbl[$];
  vec_t post[$];

  initial begin
    rstn = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_din = '0; wr_be = '0;

    tbl.push_back(mk("clr rd0",   OP_R,  0, 0, 0,    0, 32'h0, 32'h0));
    tbl.push_back(mk("clr rd31",  OP_R,  0, 0, 0,   31, 32'h0, 32'h0));
    tbl.push_back(mk("clr rd63",  OP_R,  0, 0, 0,   63, 32'h0, 32'h0));
    tbl.push_back(mk("clr rd40",  OP_R,  0, 0, 0,   40, 32'h0, 32'h0));
    tbl.push_back(mk("w5 full",   OP_W,  5, 32'h1122_3344, 4'hF, 0, 0, 0));
    tbl.push_back(mk("w5 be5",    OP_W,  5, 32'hAABB_CCDD, 4'h5, 0, 0, 0));
    tbl.push_back(mk("be merge",  OP_R,  0, 0, 0,    5, 32'h11BB_33DD, 32'h11BB_33DD));
    tbl.push_back(mk("w50",       OP_W, 50, 32'hDEAD_BEEF, 4'hF, 0, 0, 0));
    tbl.push_back(mk("rd50",      OP_R,  0, 0, 0,   50, 32'hDEAD_BEEF, 32'h0));
    tbl.push_back(mk("w47",       OP_W, 47, 32'hCAFE_F00D, 4'hF, 0, 0, 0));
    tbl.push_back(mk("rd47",      OP_R,  0, 0, 0,   47, 32'hCAFE_F00D, 32'hCAFE_F00D));
    tbl.push_back(mk("w20 be0",   OP_W, 20, 32'h1234_5678, 4'h0, 0, 0, 0));
    tbl.push_back(mk("rd20",      OP_R,  0, 0, 0,   20, 32'h0, 32'h0));
    tbl.push_back(mk("w2",        OP_W,  2, 32'h0202_0202, 4'hF, 0, 0, 0));
    tbl.push_back(mk("w3",        OP_W,  3, 32'h0303_0303, 4'hF, 0, 0, 0));
    tbl.push_back(mk("w4",        OP_W,  4, 32'h0404_0404, 4'hF, 0, 0, 0));
    tbl.push_back(mk("rdw7",      OP_RW, 7, 32'hFFFF_0000, 4'hC, 7, 32'h0, 32'hFFFF_0000));
    tbl.push_back(mk("rd7 after", OP_R,  0, 0, 0,    7, 32'hFFFF_0000, 32'hFFFF_0000));
    tbl.push_back(mk("w9",        OP_W,  9, 32'hA5A5_A5A5, 4'hF, 0, 0, 0));
    tbl.push_back(mk("rdw9 part", OP_RW, 9, 32'h5A5A_5A5A, 4'h3, 9, 32'hA5A5_A5A5, 32'hA5A5_5A5A));
    tbl.push_back(mk("rd9 after", OP_R,  0, 0, 0,    9, 32'hA5A5_5A5A, 32'hA5A5_5A5A));
    tbl.push_back(mk("w8 rd9",    OP_RW, 8, 32'h1111_1111, 4'hF, 9, 32'hA5A5_5A5A, 32'hA5A5_5A5A));
    tbl.push_back(mk("rd8",       OP_R,  0, 0, 0,    8, 32'h1111_1111, 32'h1111_1111));
    tbl.push_back(mk("w10",       OP_W, 10, 32'h7777_7777, 4'hF, 0, 0, 0));

    post.push_back(mk("re rd40",  OP_R,  0, 0, 0,   40, 32'h0, 32'h0));
    post.push_back(mk("re rd10",  OP_R,  0, 0, 0,   10, 32'h0, 32'h0));
    post.push_back(mk("re rd5",   OP_R,  0, 0, 0,    5, 32'h0, 32'h0));

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst v0", 32'(v0), 32'd0);
    chk("rst d0", d0, 32'h0);
    chk("rst v1", 32'(v1), 32'd0);
    chk("rst d1", d1, 32'h0);
    chk("rst done0", 32'(done0), 32'd0);
    chk("rst done1", 32'(done1), 32'd0);
    chk("rst done2 noclr", 32'(done2), 32'd1);

    sweep("sweep1");

    foreach (tbl[i]) apply(tbl[i]);

    // Back-to-back reads of 2,3,4: latency 1 on dut0, 2 on dut1.
    begin
      logic [31:0] dv [3];
      logic [4:0]  ev0, ev1;
      dv[0] = 32'h0202_0202; dv[1] = 32'h0303_0303; dv[2] = 32'h0404_0404;
      ev0 = 5'b00111; ev1 = 5'b01110;
      @(negedge clk);
      rd_en = 1'b1; rd_addr = 6'd2;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        if (k < 2) rd_addr = 6'(3 + k);
        else rd_en = 1'b0;
        chk($sformatf("b2b v0 k%0d", k), 32'(v0), 32'(ev0[k]));
        chk($sformatf("b2b v1 k%0d", k), 32'(v1), 32'(ev1[k]));
        chk($sformatf("b2b d0 k%0d", k), d0, dv[(k > 2) ? 2 : k]);
        if (k > 0) chk($sformatf("b2b d1 k%0d", k), d1, dv[(k > 3) ? 2 : k - 1]);
      end
    end

    // Reset with a read in flight, then a reset in the middle of the sweep.
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 6'd5;
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk("inflight v0 accepted", 32'(v0), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("inflight v0 dropped", 32'(v0), 32'd0);
    chk("inflight v1 dropped", 32'(v1), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midclr done0 low", 32'(done0), 32'd0);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midclr rst done2", 32'(done2), 32'd1);
    sweep("sweep2");

    foreach (post[i]) apply(post[i]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_sdp_be.md
Name: mem_sdp_be

Overview:
- Simple dual-port SRAM model: one write port and one read port on a single clock, with per-byte write enables.
- Adds a read-valid pipeline, configurable read latency, defined read-during-write behaviour and an optional post-reset zero-clear sequencer.
- Serves as the next-generation line/coefficient buffer for the DSP filter datapaths, where one stage writes while another stage reads.

Parameters:
- WD, 128, data width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; need not be a power of 2.
- WA, $clog2(DEPTH), address width.
- NB, WD/8, number of byte lanes (byte-enable width).
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register stage, giving latency 2.
- RDW_MODE, 0, same-address read-during-write result: 0 returns old data, 1 returns new merged data.
- CLR_ON_RST, 1, 1 runs a zero-clear sweep after reset; 0 skips it and leaves contents undefined.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- init_done  out  1  high when the memory accepts traffic.
- wr_en  in  1  write strobe.
- wr_addr  in  WA  write address.
- wr_din  in  WD  write data.
- wr_be  in  NB  byte enables; bit i covers wr_din[8i+7:8i].
- rd_en  in  1  read strobe.
- rd_addr  in  WA  read address.
- rd_dout  out  WD  read data, registered.
- rd_valid  out  1  rd_dout carries the data of an accepted read.

Behaviour:
- Reset is synchronous and active-low: sampled only at the clock edge while rstn=0.
- Values held during reset:
  - rd_dout=0, rd_valid=0, all pipeline valid bits 0.
  - Clear counter = 0.
  - FSM = CLEAR if CLR_ON_RST=1, else RUN.
  - init_done = 0 if CLR_ON_RST=1, else 1.
- Memory contents are not reset directly.
- FSM states CLEAR and RUN:
  - CLEAR: each cycle writes all-zero to address cnt, then increments cnt.
    - After the write to DEPTH-1, the FSM moves to RUN; init_done rises on that same edge.
    - The sweep therefore takes exactly DEPTH cycles after rstn is released.
    - wr_en and rd_en are ignored in CLEAR; rd_valid stays 0.
  - RUN: terminal state until the next reset.
  - Reset asserted mid-CLEAR restarts the sweep at address 0.
- Write, in RUN:
  - wr_en=1 and wr_addr<DEPTH: byte lanes with wr_be[i]=1 are updated at the edge; other lanes are unchanged.
  - wr_be=0 performs no write.
  - wr_addr>=DEPTH: the write is dropped silently.
- Read, in RUN:
  - rd_en=1 is accepted every cycle; there is no backpressure.
  - OUT_REG=0: rd_dout and rd_valid are updated at edge N+1 for a read at edge N.
  - OUT_REG=1: they are updated at edge N+2.
  - rd_valid pulses once per accepted read; back-to-back reads give a continuous rd_valid.
  - rd_dout holds its last value when rd_valid=0.
  - rd_addr>=DEPTH: returns 0 with rd_valid=1.
- Same-cycle write and read to the same address:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: enabled lanes from wr_din, others from the old word.
  - Different addresses never interact.
- A write at edge N is visible to any read accepted at edge N+1 or later, in both modes.
- A reset with reads in flight drops them: rd_valid is 0 on the following cycle.

Test Plan:
- Reset/clear: DEPTH=64, CLR_ON_RST=1; hold rstn=0 for 3 cycles, release.
  - init_done rises exactly 64 cycles after release.
  - Then read addresses 0, 31, 63 -> each returns 0 with rd_valid=1.
- Byte-enable merge: WD=32.
  - Write addr 5 = 0x11223344 with be=0xF, then 0xAABBCCDD with be=0x5.
  - Read addr 5 -> 0x11BB33DD.
- Latency: OUT_REG=0 then OUT_REG=1; reads of addr 2,3,4 on consecutive cycles.
  - rd_valid is high for 3 cycles starting 1 (resp. 2) cycles later.
  - Data appears in order.
- Read-during-write: addr 7 holds 0x00000000; write 0xFFFF0000 with be=0xC while reading addr 7 in the same cycle.
  - RDW_MODE=0 returns 0x00000000.
  - RDW_MODE=1 returns 0xFFFF0000.
  - A read on the next cycle returns 0xFFFF0000 in both modes.
- Mid-clear reset and traffic during CLEAR:
  - Assert rstn=0 at sweep address 20 -> the sweep restarts at 0; init_done rises 64 cycles after the second release.
  - wr_en=1 to addr 40 during the sweep -> addr 40 still reads 0 after init_done.
- Out of range: DEPTH=48.
  - Write addr 50 -> no memory change.
  - Read addr 50 -> rd_dout=0, rd_valid=1.
